// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM encoding and field widths for the I2C master arbiter
package i2c_pkg;
    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;
    localparam int CNT_W      = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE} state_e;
endpackage

// File: rtl/i2c_master_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester after ptr_i wins
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);
    logic [IW-1:0] j;
    // scan from lowest to highest priority so the nearest requester after ptr_i overrides
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = '0;
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (req_i[j]) begin
                idx_o    = j;
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
            end
        end
    end
    assign valid_o = |req_i;
endmodule

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one I2C byte-write master among requesters
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ACCEPT_TIMEOUT = 16,
    parameter int XFER_TIMEOUT   = 65535
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*I2C_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic                          busy,
    output logic                          m_start,
    output logic [I2C_ADDR_W-1:0]         m_addr,
    output logic [I2C_DATA_W-1:0]         m_data,
    input  logic                          m_ready
);
    localparam int IW      = $clog2(NUM_REQ);
    // the timeout fires on the cycle whose increment brings the counter to TIMEOUT-1
    localparam int ACC_LIM = ACCEPT_TIMEOUT - 2;
    localparam int XFR_LIM = XFER_TIMEOUT - 2;

    state_e                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d, done_q, done_d, err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]           ptr_q, ptr_d, own_q, own_d;
    logic [I2C_ADDR_W-1:0]   addr_q, addr_d;
    logic [I2C_DATA_W-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0]      pick_gnt;
    logic [IW-1:0]           pick_idx;
    logic                    pick_valid;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // transaction sequencer; a new grant waits out the done/err cycle so the owner can drop req
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_valid && m_ready && !(|done_q) && !(|err_q)) begin
                    grant_d = pick_gnt;
                    own_d   = pick_idx;
                    addr_d  = req_addr[int'(pick_idx)*I2C_ADDR_W +: I2C_ADDR_W];
                    data_d  = req_data[int'(pick_idx)*I2C_DATA_W +: I2C_DATA_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_ACCEPT;
            end
            WAIT_ACCEPT: begin
                if (!m_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (int'(cnt_q) >= ACC_LIM) begin
                        err_d   = grant_q;
                        ptr_d   = own_q;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (m_ready) begin
                    done_d  = grant_q;
                    ptr_d   = own_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (int'(cnt_q) >= XFR_LIM) begin
                        err_d   = grant_q;
                        ptr_d   = own_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; pointer resets so requester 0 wins first
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            own_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = state_q != IDLE;
    assign m_start = state_q == ISSUE;
    assign m_addr  = addr_q;
    assign m_data  = data_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: scoreboard bench with directed transactions and a scripted master
module tb_i2c_master_arbiter;
    localparam int REF_NONE = 0, REF_START = 1, REF_FALL = 2, REF_RISE = 3;

    typedef struct {
        bit         is_end;
        logic [3:0] v;
        logic [3:0] e;
        logic [6:0] a;
        logic [7:0] d;
        int         rk;
        int         dl;
    } exp_t;

    logic        clk = 0, reset = 1, m_ready = 1;
    logic [3:0]  req = 0;
    logic [27:0] req_addr = 0;
    logic [31:0] req_data = 0;
    logic [3:0]  grant, done, err;
    logic        busy, m_start;
    logic [6:0]  m_addr;
    logic [7:0]  m_data;

    exp_t q[$];
    exp_t ev;
    int   total = 0, bad = 0;
    int   cyc = 0, start_cyc = 0, fall_cyc = 0, rise_cyc = 0;

    i2c_master_arbiter #(.NUM_REQ(4), .ACCEPT_TIMEOUT(16), .XFER_TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
        .grant(grant), .done(done), .err(err), .busy(busy), .m_start(m_start),
        .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act, want, cyc);
        end
    endfunction

    function automatic void exp_start(input logic [3:0] g, input logic [6:0] a, input logic [7:0] d);
        exp_t x;
        x = '{is_end: 1'b0, v: g, e: 4'b0, a: a, d: d, rk: REF_NONE, dl: 0};
        q.push_back(x);
    endfunction

    function automatic void exp_end(input logic [3:0] dn, input logic [3:0] er, input int rk, input int dl);
        exp_t x;
        x = '{is_end: 1'b1, v: dn, e: er, a: 7'h0, d: 8'h0, rk: rk, dl: dl};
        q.push_back(x);
    endfunction

    // monitor: every start or completion pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (!reset && (m_start || |done || |err)) begin
            if (m_start) start_cyc = cyc;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: start=%b done=%b err=%b grant=%b", m_start, done, err, grant);
            end else begin
                ev = q.pop_front();
                chk("event_kind", {31'b0, ~m_start}, {31'b0, ev.is_end});
                if (!ev.is_end) begin
                    chk("start_grant", {28'b0, grant}, {28'b0, ev.v});
                    chk("start_addr", {25'b0, m_addr}, {25'b0, ev.a});
                    chk("start_data", {24'b0, m_data}, {24'b0, ev.d});
                end else begin
                    chk("end_done", {28'b0, done}, {28'b0, ev.v});
                    chk("end_err", {28'b0, err}, {28'b0, ev.e});
                    if (ev.rk != REF_NONE)
                        chk("end_latency", cyc - (ev.rk == REF_START ? start_cyc :
                                                  ev.rk == REF_FALL ? fall_cyc : rise_cyc), ev.dl);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scripted master: waits for m_start, optionally accepts and optionally completes
    task automatic serve(input int acc, input int low, input bit accept, input bit finish);
        int n = 0;
        while (!m_start && n < 50) begin
            tick();
            n++;
        end
        if (!m_start) begin
            total++;
            bad++;
            $display("FAIL start_timeout: m_start=0 want=1");
        end else if (accept) begin
            repeat (acc) tick();
            m_ready  = 0;
            fall_cyc = cyc;
            if (finish) begin
                repeat (low) tick();
                m_ready  = 1;
                rise_cyc = cyc;
            end
        end
    endtask

    // requester side: wait for the done/err pulse, then drop the listed requests
    task automatic wait_end(input logic [3:0] drop);
        int n = 0;
        while (!(|done || |err) && n < 300) begin
            tick();
            n++;
        end
        if (!(|done || |err)) begin
            total++;
            bad++;
            $display("FAIL end_timeout: done=%b err=%b want a pulse", done, err);
        end
        req = req & ~drop;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        reset = 0;
        chk("rst_grant", {28'b0, grant}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_start", {31'b0, m_start}, 0);
        chk("rst_addr", {25'b0, m_addr}, 0);
        chk("rst_data", {24'b0, m_data}, 0);
        chk("rst_done_err", {24'b0, done, err}, 0);

        // single request; latched fields must ignore later slice changes
        req_addr[6:0] = 7'h50;
        req_data[7:0] = 8'hA5;
        exp_start(4'b0001, 7'h50, 8'hA5);
        exp_end(4'b0001, 4'b0000, REF_RISE, 1);
        req = 4'b0001;
        tick();
        req_addr[6:0] = 7'h7F;
        req_data[7:0] = 8'h00;
        serve(3, 40, 1, 1);
        chk("hold_addr", {25'b0, m_addr}, 32'h50);
        chk("hold_data", {24'b0, m_data}, 32'hA5);
        chk("hold_grant", {28'b0, grant}, 32'h1);
        wait_end(4'b0001);
        tick();
        chk("grant_clear", {28'b0, grant}, 0);

        // contention from a fresh pointer: order 0,1,3 repeated
        do_reset();
        req_addr = {7'h13, 7'h12, 7'h11, 7'h10};
        req_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        req = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            int o;
            o = (i % 3 == 2) ? 3 : i % 3;
            exp_start(4'(1 << o), 7'(7'h10 + o), 8'(8'hC0 + o));
            exp_end(4'(1 << o), 4'b0000, REF_RISE, 1);
            serve(1, 5, 1, 1);
            wait_end(4'b0000);
        end
        req = 0;
        tick();

        // accept timeout on requester 0, then requester 1 is served
        exp_start(4'b0001, 7'h10, 8'hC0);
        exp_end(4'b0000, 4'b0001, REF_START, 16);
        exp_start(4'b0010, 7'h11, 8'hC1);
        exp_end(4'b0010, 4'b0000, REF_RISE, 1);
        req = 4'b0011;
        serve(0, 0, 0, 0);
        wait_end(4'b0001);
        serve(2, 4, 1, 1);
        wait_end(4'b0010);
        tick();

        // hung transfer on requester 2
        exp_start(4'b0100, 7'h12, 8'hC2);
        exp_end(4'b0000, 4'b0100, REF_FALL, 100);
        req = 4'b0100;
        serve(2, 0, 1, 0);
        wait_end(4'b0100);
        tick();
        chk("hung_busy", {31'b0, busy}, 0);
        chk("hung_grant", {28'b0, grant}, 0);
        m_ready = 1;
        tick();

        // master not ready: nothing may be granted
        m_ready = 0;
        req = 4'b0010;
        repeat (6) begin
            tick();
            chk("nrdy_grant", {28'b0, grant}, 0);
            chk("nrdy_busy", {31'b0, busy}, 0);
        end
        exp_start(4'b0010, 7'h11, 8'hC1);
        exp_end(4'b0010, 4'b0000, REF_RISE, 1);
        m_ready = 1;
        serve(3, 6, 1, 1);
        wait_end(4'b0010);
        tick();

        // reset during WAIT_DONE; afterwards requester 0 must win over 2
        req_addr = {7'h23, 7'h22, 7'h21, 7'h20};
        req_data = {8'h93, 8'h92, 8'h91, 8'h90};
        exp_start(4'b0100, 7'h22, 8'h92);
        req = 4'b0100;
        serve(2, 0, 1, 0);
        repeat (5) tick();
        chk("pre_rst_busy", {31'b0, busy}, 1);
        req = 0;
        m_ready = 1;
        do_reset();
        chk("mid_rst_grant", {28'b0, grant}, 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_addr", {25'b0, m_addr}, 0);
        repeat (3) tick();
        exp_start(4'b0001, 7'h20, 8'h90);
        exp_end(4'b0001, 4'b0000, REF_RISE, 1);
        exp_start(4'b0100, 7'h22, 8'h92);
        exp_end(4'b0100, 4'b0000, REF_RISE, 1);
        req = 4'b0101;
        serve(1, 3, 1, 1);
        wait_end(4'b0001);
        serve(1, 3, 1, 1);
        wait_end(4'b0100);

        repeat (5) tick();
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
- Shares one I2C byte-write master (start/addr/data/ready handshake) among NUM_REQ requesters.
- Uses round-robin arbitration, one transaction at a time.
- Sequences each transaction: latch, start pulse, accept wait, completion wait. Returns a per-requester done or err pulse.
- Sits between the requester FIFOs/logic and the I2C master, in the master's clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ACCEPT_TIMEOUT, 16, max cycles from m_start until m_ready must fall.
- XFER_TIMEOUT, 65535, max cycles m_ready may stay low before the transfer is declared hung.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held high until own done/err.
- req_addr  in  NUM_REQ*7  packed 7-bit slave addresses; requester i at [7i+6:7i].
- req_data  in  NUM_REQ*8  packed data bytes; requester i at [8i+7:8i].
- grant  out  NUM_REQ  one-hot owner of the current transaction; zero when idle.
- done  out  NUM_REQ  one-cycle pulse to the owner on successful completion.
- err  out  NUM_REQ  one-cycle pulse to the owner on timeout.
- busy  out  1  high in any state other than IDLE.
- m_start  out  1  one-cycle start pulse to the I2C master.
- m_addr  out  7  latched address to the master.
- m_data  out  8  latched data to the master.
- m_ready  in  1  master idle/ready indication.

Behaviour:
- Reset values:
  - state=IDLE; grant, done, err all 0.
  - busy=0, m_start=0, m_addr=0, m_data=0.
  - rr_ptr=NUM_REQ-1, so requester 0 wins first. Counter=0.
- State machine (registered outputs):
  - IDLE: if |req and m_ready=1, pick the winner by round-robin starting at rr_ptr+1 (mod NUM_REQ). Then:
    - set grant[winner];
    - latch m_addr/m_data from the winner's slice;
    - go to ISSUE.
    - If m_ready=0, stay in IDLE and grant nothing.
  - ISSUE: m_start=1 for exactly this one cycle; clear counter; go to WAIT_ACCEPT.
  - WAIT_ACCEPT:
    - if m_ready=0, clear counter and go to WAIT_DONE;
    - else increment counter;
    - when counter reaches ACCEPT_TIMEOUT-1 with m_ready still 1, pulse err[owner] and go to IDLE.
  - WAIT_DONE:
    - if m_ready=1, pulse done[owner] and go to IDLE;
    - else increment counter;
    - when counter reaches XFER_TIMEOUT-1, pulse err[owner] and go to IDLE.
- rr_ptr update: set to the owner index on leaving WAIT_ACCEPT/WAIT_DONE, for both done and err.
- grant timing: asserted from the ISSUE entry cycle through the done/err cycle inclusive. Cleared the cycle after.
- done/err are mutually exclusive and last 1 cycle.
- Latency, best case: req high in IDLE → m_start 2 cycles later (IDLE→ISSUE register, then the ISSUE cycle). Master completion (m_ready rise) → done pulse 1 cycle later.
- m_addr/m_data are stable from ISSUE until the next grant. Changes to req_addr/req_data after latch are ignored.
- A requester dropping req mid-transaction does not abort it; done/err still pulse to it.
- A requester holding req high after done is eligible again, at lowest priority relative to the others.
- Simultaneous requests: the lowest index at or after rr_ptr+1 wins. Wrap from NUM_REQ-1 to 0.
- Counter is 16 bits; both timeouts must be ≤ 65536.
- reset mid-transaction: everything returns to reset values next cycle. No done/err is emitted. The master must be reset by the same reset.

Decomposition:
- Shared package i2c_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, 2 bits);
  - I2C_ADDR_W=7, I2C_DATA_W=8;
  - the 16-bit counter width constant.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot winner, its index, and a valid flag.
  - Instantiated once.

Test Plan:
- Single request: req=4'b0001, addr=0x50, data=0xA5, master drops ready 3 cycles after start and raises it 40 cycles later. Expect:
  - m_start 1 cycle, 2 cycles after req;
  - m_addr=0x50, m_data=0xA5;
  - grant=0001;
  - done[0] one cycle after the ready rise.
- Contention: req=4'b1011 held continuously. Expect grant order 0,1,3,0,1,3 with one done per grant.
- Accept timeout: the master never drops ready after m_start. Expect err[owner] exactly ACCEPT_TIMEOUT cycles after m_start, no done, return to IDLE, and the next requester served.
- Hung transfer: run with XFER_TIMEOUT=100 and hold ready low. Expect err 100 cycles after entry to WAIT_DONE and busy=0 the next cycle.
- Master not ready: m_ready=0 while req=0010. Expect no grant or m_start until m_ready=1, then normal sequence.
- Reset mid-WAIT_DONE: assert reset for 1 cycle. Expect grant=0, busy=0, no done/err, and requester 0 wins first afterwards.
